ask_tx_controller: RTL

- Sequences the ASK modulator. Accepts data words over a valid/ready handshake and frames each word as preamble + data + gap.
- Serializes each frame into a bit stream held for a fixed number of clocks per bit.
- Generates the square-wave carrier.
- Drives the modulator's data_in and carrier inputs directly. Sits between the packet/CPU side and the modulator.

---
 rtl/ask_pkg.sv | 32 +++
 rtl/ask_tx_controller_if.sv | 12 +
 rtl/ask_carrier_gen.sv | 32 +++
 rtl/ask_tx_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ask_pkg.sv
// Shared types and defaults for the ASK transmit path (controller, carrier generator).
// Optional parity bit is controlled by the ASK_TX_PARITY_EN macro in ask_tx_controller.
package ask_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        GAP      = 3'd4
    } ask_state_e;

    localparam logic PREAMBLE_START = 1'b1;

    localparam int DEF_DATA_W         = 8;
    localparam int DEF_CYCLES_PER_BIT = 32;
    localparam int DEF_CARRIER_HALF   = 4;
    localparam int DEF_PREAMBLE_BITS  = 8;
    localparam int DEF_GAP_BITS       = 2;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ask_tx_controller_if.sv
// Payload handshake between the packet/CPU side (master) and the ASK controller (slave).
// valid/ready: a word transfers on any clk edge where tx_valid && tx_ready; tx_data must be stable while tx_valid is high.
interface ask_tx_controller_if #(parameter int DATA_W = 8);

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/ask_carrier_gen.sv
// Free-running square-wave carrier, period 2*CARRIER_HALF clocks; held low while disabled.
module ask_carrier_gen #(
    parameter int CARRIER_HALF = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic carrier
);
    import ask_pkg::*;

    localparam int                CNT_W    = cnt_width(CARRIER_HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CARRIER_HALF - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            carrier <= 1'b0;
        end else if (!enable) begin
            cnt     <= '0;
            carrier <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            carrier <= ~carrier;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ask_tx_controller.sv
// Frames each accepted word as preamble + data (+ parity when ASK_TX_PARITY_EN is defined) + gap,
// serialises it at CYCLES_PER_BIT clocks per bit and drives the modulator data/carrier inputs.
module ask_tx_controller
    import ask_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int CYCLES_PER_BIT = DEF_CYCLES_PER_BIT,
    parameter int CARRIER_HALF   = DEF_CARRIER_HALF,
    parameter int PREAMBLE_BITS  = DEF_PREAMBLE_BITS,
    parameter int GAP_BITS       = DEF_GAP_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    ask_tx_controller_if.slave  tx,
    output logic                mod_data,
    output logic                mod_carrier,
    output logic                busy,
    output logic                bit_strobe,
    output logic [2:0]          state_dbg
);

    localparam logic [2:0] S_IDLE     = IDLE;
    localparam logic [2:0] S_PREAMBLE = PREAMBLE;
    localparam logic [2:0] S_DATA     = DATA;
    localparam logic [2:0] S_PARITY   = PARITY;
    localparam logic [2:0] S_GAP      = GAP;

    localparam int IDX_W = cnt_width(max3(PREAMBLE_BITS, DATA_W, GAP_BITS));
    localparam int TMR_W = cnt_width(CYCLES_PER_BIT);

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_BITS - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_BITS - 1);

`ifdef ASK_TX_PARITY_EN
    localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [2:0] S_AFTER_DATA = S_GAP;
`endif

    logic [2:0]        state,     state_nxt;
    logic [TMR_W-1:0]  bit_timer, timer_nxt;
    logic [IDX_W-1:0]  bit_idx,   idx_nxt;
    logic [DATA_W-1:0] shreg,     shreg_nxt;
    logic              alive_q;
    logic              accept;

    // tx_ready stays low until the first edge after reset release.
    assign tx.tx_ready = (state == S_IDLE) && enable && alive_q;
    assign accept      = tx.tx_valid && tx.tx_ready;
    assign busy        = (state != S_IDLE);
    assign bit_strobe  = busy && (bit_timer == TMR_LAST);
    assign state_dbg   = state;

`ifdef ASK_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^tx.tx_data;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        timer_nxt = bit_timer;
        idx_nxt   = bit_idx;
        shreg_nxt = shreg;
        if (!enable) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
            idx_nxt   = '0;
        end else if (state == S_IDLE) begin
            if (accept) begin
                state_nxt = S_PREAMBLE;
                timer_nxt = '0;
                idx_nxt   = '0;
                shreg_nxt = tx.tx_data;
            end
        end else begin
            timer_nxt = bit_strobe ? '0 : bit_timer + 1'b1;
            if (bit_strobe) begin
                idx_nxt = bit_idx + 1'b1;
                case (state)
                    S_PREAMBLE: begin
                        if (bit_idx == PRE_LAST) begin
                            state_nxt = S_DATA;
                            idx_nxt   = '0;
                        end
                    end
                    S_DATA: begin
                        shreg_nxt = shreg >> 1;
                        if (bit_idx == DATA_LAST) begin
                            state_nxt = S_AFTER_DATA;
                            idx_nxt   = '0;
                        end
                    end
`ifdef ASK_TX_PARITY_EN
                    S_PARITY: begin
                        state_nxt = S_GAP;
                        idx_nxt   = '0;
                    end
`endif
                    S_GAP: begin
                        if (bit_idx == GAP_LAST) begin
                            state_nxt = S_IDLE;
                            idx_nxt   = '0;
                        end
                    end
                    default: begin
                        state_nxt = S_IDLE;
                        idx_nxt   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            alive_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_timer <= timer_nxt;
            bit_idx   <= idx_nxt;
            shreg     <= shreg_nxt;
            alive_q   <= 1'b1;
        end
    end

    // Preamble alternates starting from PREAMBLE_START, so odd indices carry its complement.
    always_comb begin
        case (state)
            S_PREAMBLE: mod_data = bit_idx[0] ? ~PREAMBLE_START : PREAMBLE_START;
            S_DATA:     mod_data = shreg[0];
`ifdef ASK_TX_PARITY_EN
            S_PARITY:   mod_data = parity_q;
`endif
            default:    mod_data = 1'b0;
        endcase
    end

    ask_carrier_gen #(
        .CARRIER_HALF(CARRIER_HALF)
    ) u_carrier (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .carrier (mod_carrier)
    );

endmodule
